// File: rtl/bypass_ctrl.sv
// bypass_ctrl: ID-stage forwarding select generation, load-use bubble insertion and pipeline stall/flush control.
module bypass_ctrl #(
  parameter int RF_ADDR_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RF_ADDR_W-1:0] p0_addr,
  input  logic [RF_ADDR_W-1:0] p1_addr,
  input  logic                 re0,
  input  logic                 re1,
  input  logic [RF_ADDR_W-1:0] dst_addr_ID,
  input  logic                 we_rf_ID,
  input  logic                 mem_rd_ID,
  input  logic                 flush,
  input  logic                 stall_ext,
  output logic                 byp0_EX,
  output logic                 byp0_DM,
  output logic                 byp1_EX,
  output logic                 byp1_DM,
  output logic                 stall_IM_ID,
  output logic                 stall_ID_EX,
  output logic                 stall_EX_DM,
  output logic                 bubble_ID_EX,
  output logic [CNT_W-1:0]     lu_cnt
);
  logic                 v_ex_q, v_ex_d, we_ex_q, we_ex_d, ld_ex_q, ld_ex_d;
  logic [RF_ADDR_W-1:0] dst_ex_q, dst_ex_d;
  logic                 v_dm_q, v_dm_d, we_dm_q, we_dm_d;
  logic [RF_ADDR_W-1:0] dst_dm_q, dst_dm_d;
  logic [3:0]           byp_q, byp_d, byp_nx;
  logic [CNT_W-1:0]     lu_cnt_q, lu_cnt_d;
  logic                 m0_ex, m1_ex, m0_dm, m1_dm, lu, b0e, b1e;
  assign m0_ex = v_ex_q & we_ex_q & (dst_ex_q == p0_addr) & (p0_addr != '0);
  assign m1_ex = v_ex_q & we_ex_q & (dst_ex_q == p1_addr) & (p1_addr != '0);
  assign m0_dm = v_dm_q & we_dm_q & (dst_dm_q == p0_addr) & (p0_addr != '0);
  assign m1_dm = v_dm_q & we_dm_q & (dst_dm_q == p1_addr) & (p1_addr != '0);
  // A killed instruction in ID never causes a load-use stall.
  assign lu  = ~flush & ld_ex_q & ((re0 & m0_ex) | (re1 & m1_ex));
  assign b0e = re0 & m0_ex & ~ld_ex_q;
  assign b1e = re1 & m1_ex & ~ld_ex_q;
  // EX wins over DM: it holds the most recent producer.
  assign byp_nx = {b0e, re0 & m0_dm & ~b0e, b1e, re1 & m1_dm & ~b1e};
  assign stall_IM_ID  = stall_ext | lu;
  assign stall_ID_EX  = stall_ext;
  assign stall_EX_DM  = stall_ext;
  assign bubble_ID_EX = ~stall_ext & (lu | flush);
  assign {byp0_EX, byp0_DM, byp1_EX, byp1_DM} = byp_q;
  assign lu_cnt = lu_cnt_q;
  always_comb begin
    v_dm_d   = stall_ext ? v_dm_q   : v_ex_q;
    we_dm_d  = stall_ext ? we_dm_q  : we_ex_q;
    dst_dm_d = stall_ext ? dst_dm_q : dst_ex_q;
    v_ex_d   = stall_ext ? v_ex_q   : ~bubble_ID_EX;
    we_ex_d  = stall_ext ? we_ex_q  : we_rf_ID & ~bubble_ID_EX;
    ld_ex_d  = stall_ext ? ld_ex_q  : mem_rd_ID & ~bubble_ID_EX;
    dst_ex_d = stall_ext ? dst_ex_q : (bubble_ID_EX ? '0 : dst_addr_ID);
    byp_d    = stall_ext ? byp_q    : (bubble_ID_EX ? '0 : byp_nx);
    lu_cnt_d = (lu & ~stall_ext & ~&lu_cnt_q) ? lu_cnt_q + CNT_W'(1) : lu_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v_ex_q   <= 1'b0;
      we_ex_q  <= 1'b0;
      ld_ex_q  <= 1'b0;
      dst_ex_q <= '0;
      v_dm_q   <= 1'b0;
      we_dm_q  <= 1'b0;
      dst_dm_q <= '0;
      byp_q    <= '0;
      lu_cnt_q <= '0;
    end else begin
      v_ex_q   <= v_ex_d;
      we_ex_q  <= we_ex_d;
      ld_ex_q  <= ld_ex_d;
      dst_ex_q <= dst_ex_d;
      v_dm_q   <= v_dm_d;
      we_dm_q  <= we_dm_d;
      dst_dm_q <= dst_dm_d;
      byp_q    <= byp_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end
endmodule

// File: tb/tb_bypass_ctrl.sv
// tb_bypass_ctrl: directed per-cycle vectors; expected outputs queued by the driver, compared by a negedge monitor.
module tb_bypass_ctrl;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int OW = 8 + CW;
  typedef struct {
    string         nm;
    logic [OW-1:0] v;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_addr, p1_addr, dst_addr_ID;
  logic          re0, re1, we_rf_ID, mem_rd_ID, flush, stall_ext;
  logic          byp0_EX, byp0_DM, byp1_EX, byp1_DM;
  logic          stall_IM_ID, stall_ID_EX, stall_EX_DM, bubble_ID_EX;
  logic [CW-1:0] lu_cnt;
  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bypass_ctrl #(.RF_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
    .dst_addr_ID(dst_addr_ID), .we_rf_ID(we_rf_ID), .mem_rd_ID(mem_rd_ID), .flush(flush),
    .stall_ext(stall_ext), .byp0_EX(byp0_EX), .byp0_DM(byp0_DM), .byp1_EX(byp1_EX),
    .byp1_DM(byp1_DM), .stall_IM_ID(stall_IM_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_DM(stall_EX_DM), .bubble_ID_EX(bubble_ID_EX), .lu_cnt(lu_cnt)
  );
  always #5 clk = ~clk;
  function automatic int sat(int n);
    return n > 15 ? 15 : n;
  endfunction
  // Inputs held for one cycle; expected = outputs seen during that same cycle.
  // eb = {b0e,b0d,b1e,b1d}, es = {IM_ID,ID_EX,EX_DM}, eu = bubble, ec = lu_cnt.
  task automatic cyc(input string nm, input int a0, input int a1, input int r0, input int r1,
                     input int d, input int w, input int l, input int f, input int s, input int rs,
                     input int eb, input int es, input int eu, input int ec);
    exp_t e;
    @(posedge clk);
    #1;
    p0_addr = AW'(a0); p1_addr = AW'(a1); re0 = r0[0]; re1 = r1[0];
    dst_addr_ID = AW'(d); we_rf_ID = w[0]; mem_rd_ID = l[0];
    flush = f[0]; stall_ext = s[0]; rst = rs[0];
    e.nm = nm;
    e.v  = {4'(eb), 3'(es), 1'(eu), CW'(ec)};
    exp_q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    logic [OW-1:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {byp0_EX, byp0_DM, byp1_EX, byp1_DM, stall_IM_ID, stall_ID_EX, stall_EX_DM,
               bubble_ID_EX, lu_cnt};
        checks++;
        if (act !== e.v) begin
          errors++;
          $display("FAIL %s: got byp=%b stall=%b bub=%b cnt=%0d, want byp=%b stall=%b bub=%b cnt=%0d",
                   e.nm, act[OW-1-:4], act[OW-5-:3], act[CW], act[CW-1:0],
                   e.v[OW-1-:4], e.v[OW-5-:3], e.v[CW], e.v[CW-1:0]);
        end
      end
    end
  end
  initial begin : driver
    rst = 1'b1; p0_addr = '0; p1_addr = '0; re0 = 1'b0; re1 = 1'b0;
    dst_addr_ID = '0; we_rf_ID = 1'b0; mem_rd_ID = 1'b0; flush = 1'b0; stall_ext = 1'b0;
    repeat (2) @(posedge clk);
    cyc("reset_state", 0,0,0,0, 0,0,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("alu_w_r3",    0,0,0,0, 3,1,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("alu_rd_r3",   3,3,1,1, 5,1,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("alu_ex_byp",  0,0,0,0, 0,0,0, 0,0,0, 'b1010,'b000,0,0);
    cyc("d2_w_r4",     0,0,0,0, 4,1,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("d2_unrel",    0,0,0,0, 7,0,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("d2_rd_r4",    0,4,0,1, 0,0,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("d2_dm_byp",   0,0,0,0, 0,0,0, 0,0,0, 'b0001,'b000,0,0);
    cyc("dp_w1_r2",    0,0,0,0, 2,1,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("dp_w2_r2",    0,0,0,0, 2,1,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("dp_rd_r2",    2,0,1,0, 0,0,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("dp_ex_prio",  0,0,0,0, 0,0,0, 0,0,0, 'b1000,'b000,0,0);
    cyc("lu_lw_r6",    0,0,0,0, 6,1,1, 0,0,0, 'b0000,'b000,0,0);
    cyc("lu_detect",   6,0,1,0, 8,1,0, 0,0,0, 'b0000,'b100,1,0);
    cyc("lu_retry",    6,0,1,0, 8,1,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("lu_dm_byp",   0,0,0,0, 0,0,0, 0,0,0, 'b0100,'b000,0,1);
    cyc("r0_write",    0,0,0,0, 0,1,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("r0_read",     0,0,1,1, 0,0,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("r0_no_byp",   0,0,0,0, 0,0,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("re_w_r9",     0,0,0,0, 9,1,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("re_rd_r9",    9,9,1,0, 0,0,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("re1_off",     0,0,0,0, 0,0,0, 0,0,0, 'b1000,'b000,0,1);
    cyc("fl_lw_r6",    0,0,0,0, 6,1,1, 0,0,0, 'b0000,'b000,0,1);
    cyc("fl_over_lu",  6,0,1,0, 8,1,0, 1,0,0, 'b0000,'b000,1,1);
    cyc("fl_after",    0,0,0,0, 0,0,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("st_w_r5",     0,0,0,0, 5,1,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("st_rd_r5",    5,5,1,1, 0,0,0, 0,0,0, 'b0000,'b000,0,1);
    cyc("st_hold1",    5,0,1,0, 0,0,0, 0,1,0, 'b1010,'b111,0,1);
    cyc("st_hold2",    5,0,1,0, 0,0,0, 0,1,0, 'b1010,'b111,0,1);
    cyc("st_hold3",    5,0,1,0, 0,0,0, 0,1,0, 'b1010,'b111,0,1);
    cyc("st_release",  5,0,1,0, 0,0,0, 0,0,0, 'b1010,'b000,0,1);
    cyc("st_frozen",   0,0,0,0, 0,0,0, 0,0,0, 'b0100,'b000,0,1);
    cyc("slu_lw_r6",   0,0,0,0, 6,1,1, 0,0,0, 'b0000,'b000,0,1);
    cyc("slu_hold",    6,0,1,0, 8,1,0, 0,1,0, 'b0000,'b111,0,1);
    cyc("slu_bubble",  6,0,1,0, 8,1,0, 0,0,0, 'b0000,'b100,1,1);
    cyc("slu_retry",   6,0,1,0, 8,1,0, 0,0,0, 'b0000,'b000,0,2);
    cyc("slu_dm_byp",  0,0,0,0, 0,0,0, 0,0,0, 'b0100,'b000,0,2);
    cyc("rs_w_r3",     0,0,0,0, 3,1,0, 0,0,0, 'b0000,'b000,0,2);
    cyc("rs_ld_r3",    3,0,1,0, 3,1,1, 0,0,0, 'b0000,'b000,0,2);
    cyc("rs_assert",   3,3,1,1, 0,0,0, 0,0,1, 'b1000,'b100,1,2);
    cyc("rs_cleared",  3,3,1,1, 0,0,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("rs_idle",     0,0,0,0, 0,0,0, 0,0,0, 'b0000,'b000,0,0);
    cyc("sat_pre",     6,0,1,0, 6,1,1, 0,0,0, 'b0000,'b000,0,0);
    for (int k = 1; k <= 18; k++) begin
      cyc("sat_lu",    6,0,1,0, 6,1,1, 0,0,0, k == 1 ? 'b0000 : 'b0100, 'b100,1,sat(k-1));
      cyc("sat_gap",   6,0,1,0, 6,1,1, 0,0,0, 'b0000,'b000,0,sat(k));
    end
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
